// File: rtl/pe_pkg.sv
// Shared PE definitions: widths, accumulator FSM states and saturating add.
package pe_pkg;

  localparam int unsigned DATA_W    = 15;
  localparam int unsigned ACT_W     = 8;
  localparam int unsigned SHIFT_W   = 4;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned CNT_W_DEF = 8;
  // Widest accumulator the saturating add supports.
  localparam int unsigned MAX_ACC_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pe_state_e;

  typedef logic signed [MAX_ACC_W-1:0] acc_wide_t;

  typedef struct packed {
    logic      ovf;
    acc_wide_t sum;
  } sat_res_t;

  // Signed add clamped to a w-bit two's complement range; ovf flags a clamp.
  function automatic sat_res_t sat_add(input acc_wide_t a, input acc_wide_t b,
                                       input int unsigned w);
    logic signed [MAX_ACC_W:0] s;
    logic signed [MAX_ACC_W:0] hi;
    logic signed [MAX_ACC_W:0] lo;
    sat_res_t                  r;
    s  = (MAX_ACC_W+1)'(a) + (MAX_ACC_W+1)'(b);
    hi = (MAX_ACC_W+1)'((64'd1 << (w - 1)) - 64'd1);
    lo = ~hi;
    r.ovf = (s > hi) || (s < lo);
    if (s > hi) begin
      r.sum = MAX_ACC_W'(hi);
    end else if (s < lo) begin
      r.sum = MAX_ACC_W'(lo);
    end else begin
      r.sum = MAX_ACC_W'(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_requant.sv
// Requantiser: ReLU, arithmetic right shift, clamp to the activation range.
module pe_requant
  import pe_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]   x,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [ACT_W-1:0]   act_c
);

  localparam logic signed [ACC_W-1:0] ACT_MAX = ACC_W'((1 << ACT_W) - 1);

  logic signed [ACC_W-1:0] y;

  // Non-positive inputs map to zero; positive ones are shifted then clamped.
  always_comb begin
    act_c = '0;
    y     = x >>> shift;
    if (!x[ACC_W-1] && (x != '0)) begin
      act_c = (y > ACT_MAX) ? ACT_W'(ACT_MAX) : ACT_W'(y);
    end
  end

endmodule

// File: rtl/pe_accumulator.sv
// Window accumulator: sums shift-products onto a bias, then requantises.
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic signed [ACC_W-1:0]  i_bias,
  input  logic        [CNT_W-1:0]  i_num_terms,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic        [ACT_W-1:0]  o_act,
  output logic                     o_overflow
);

  pe_state_e               state;
  pe_state_e               state_next;
  pe_state_e               start_state_c;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        num_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic                    accept_c;
  logic                    last_c;
  sat_res_t                sat_c;
  logic [ACT_W-1:0]        act_c;

  pe_requant #(.ACC_W(ACC_W)) u_requant (
    .x     (acc),
    .shift (shift_q),
    .act_c (act_c)
  );

  // Next-state logic; a start always wins over a term arriving the same cycle.
  always_comb begin
    state_next    = state;
    start_state_c = (i_num_terms == '0) ? DONE : ACCUM;
    accept_c      = (state == ACCUM) && i_valid && !i_start;
    last_c        = accept_c && ((cnt + CNT_W'(1)) == num_q);
    sat_c         = sat_add(MAX_ACC_W'(acc), MAX_ACC_W'(i_data), ACC_W);
    case (state)
      IDLE: begin
        if (i_start) state_next = start_state_c;
      end
      ACCUM: begin
        if (i_start)     state_next = start_state_c;
        else if (last_c) state_next = DONE;
      end
      DONE: begin
        state_next = i_start ? start_state_c : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, accumulator datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      num_q      <= '0;
      shift_q    <= '0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_sum      <= '0;
      o_act      <= '0;
      o_overflow <= 1'b0;
    end else begin
      state   <= state_next;
      o_busy  <= (state_next == ACCUM);
      o_valid <= (state_next == DONE);
      if (state == DONE) begin
        o_sum <= acc;
        o_act <= act_c;
      end
      if (i_start) begin
        acc        <= i_bias;
        cnt        <= '0;
        num_q      <= i_num_terms;
        shift_q    <= i_shift;
        o_overflow <= 1'b0;
      end else if (accept_c) begin
        acc <= ACC_W'(sat_c.sum);
        cnt <= cnt + CNT_W'(1);
        if (sat_c.ovf) o_overflow <= 1'b1;
      end
    end
  end

endmodule
